// File: rtl/pipelined_fractional_multiplier_if.sv
// Streaming handshake bundle for the pipelined fractional multiplier:
// operand side (in_*) and result side (out_*).
interface pipelined_fractional_multiplier_if #(
    parameter int A_WIDTH      = 16,
    parameter int B_WIDTH      = 16,
    parameter int OUTPUT_WIDTH = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [A_WIDTH-1:0]      a;
    logic [B_WIDTH-1:0]      b;
    logic                    round_mode;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUTPUT_WIDTH-1:0] result;
    logic                    overflow;

    modport master (
        output in_valid, a, b, round_mode, out_ready,
        input  in_ready, out_valid, result, overflow
    );

    modport slave (
        input  in_valid, a, b, round_mode, out_ready,
        output in_ready, out_valid, result, overflow
    );
endinterface

// File: rtl/pipelined_fractional_multiplier.sv
// Pipelined fixed-point multiplier: full product in stage 1, pure delay stages,
// then scale/round/saturate in the final stage. Whole pipe stalls on backpressure.
module pipelined_fractional_multiplier #(
    parameter int A_WIDTH            = 16,
    parameter int B_WIDTH            = 16,
    parameter int OUTPUT_WIDTH       = 16,
    parameter int FRAC_BITS_A        = 4,
    parameter int FRAC_BITS_B        = 4,
    parameter int FRAC_BITS_OUT      = 8,
    parameter int ARE_SIGNALS_SIGNED = 1,
    parameter int PIPE_STAGES        = 2
) (
    input logic clk,
    input logic reset,
    pipelined_fractional_multiplier_if.slave bus
);
    localparam int P_WIDTH   = A_WIDTH + B_WIDTH;
    localparam int SHIFT     = FRAC_BITS_A + FRAC_BITS_B - FRAC_BITS_OUT;
    localparam int R_SHIFT   = (SHIFT > 0) ? SHIFT : 0;
    localparam int L_SHIFT   = (SHIFT < 0) ? -SHIFT : 0;
    localparam int ROUND_BIT = (SHIFT > 0) ? SHIFT - 1 : 0;
    // Room for the left shift, the rounding carry and a sign bit in unsigned mode.
    localparam int W_RAW     = P_WIDTH + L_SHIFT + 2;
    localparam int W         = (W_RAW > OUTPUT_WIDTH + 2) ? W_RAW : OUTPUT_WIDTH + 2;
    localparam int LAST      = PIPE_STAGES - 2;

    localparam logic signed [W-1:0] ROUND_CONST = W'(1) << ROUND_BIT;
    localparam logic signed [W-1:0] MAX_V = (ARE_SIGNALS_SIGNED != 0)
        ? (W'(1) << (OUTPUT_WIDTH - 1)) - W'(1)
        : (W'(1) << OUTPUT_WIDTH) - W'(1);
    localparam logic signed [W-1:0] MIN_V = (ARE_SIGNALS_SIGNED != 0)
        ? -(W'(1) << (OUTPUT_WIDTH - 1))
        : '0;

    logic [P_WIDTH-1:0]      p_q [PIPE_STAGES-1];
    logic [P_WIDTH-1:0]      p_d [PIPE_STAGES-1];
    logic [PIPE_STAGES-2:0]  vld_q, vld_d;
    logic [PIPE_STAGES-2:0]  rm_q, rm_d;
    logic                    out_valid_q, out_valid_d;
    logic [OUTPUT_WIDTH-1:0] result_q, result_d;
    logic                    overflow_q, overflow_d;
    logic                    adv;
    logic signed [W-1:0]     ext, rounded, scaled;

    always_comb begin
        adv = bus.out_ready | ~out_valid_q;

        if (ARE_SIGNALS_SIGNED != 0) begin
            p_d[0] = P_WIDTH'($signed(bus.a)) * P_WIDTH'($signed(bus.b));
        end else begin
            p_d[0] = P_WIDTH'(bus.a) * P_WIDTH'(bus.b);
        end
        vld_d[0] = bus.in_valid;
        rm_d[0]  = bus.round_mode;
        for (int unsigned i = 1; i < unsigned'(PIPE_STAGES - 1); i++) begin
            p_d[i]   = p_q[i-1];
            vld_d[i] = vld_q[i-1];
            rm_d[i]  = rm_q[i-1];
        end

        if (ARE_SIGNALS_SIGNED != 0) begin
            ext = W'($signed(p_q[LAST]));
        end else begin
            ext = W'(p_q[LAST]);
        end
        rounded = ((SHIFT > 0) && rm_q[LAST]) ? ext + ROUND_CONST : ext;
        // At most one of the two shifts is non-zero.
        scaled  = (rounded >>> R_SHIFT) <<< L_SHIFT;

        overflow_d = 1'b0;
        result_d   = scaled[OUTPUT_WIDTH-1:0];
        if (scaled > MAX_V) begin
            overflow_d = 1'b1;
            result_d   = MAX_V[OUTPUT_WIDTH-1:0];
        end else if (scaled < MIN_V) begin
            overflow_d = 1'b1;
            result_d   = MIN_V[OUTPUT_WIDTH-1:0];
        end
        out_valid_d = vld_q[LAST];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_q         <= '{default: '0};
            vld_q       <= '0;
            rm_q        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
        end else if (adv) begin
            p_q         <= p_d;
            vld_q       <= vld_d;
            rm_q        <= rm_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_pipelined_fractional_multiplier.sv
// Four differently parameterised multipliers share one stimulus stream; each has
// its own queue-based reference that predicts value, order and latency.
module tb_pipelined_fractional_multiplier;
    localparam int N = 4;
    localparam int PIPE [N] = '{2, 2, 3, 5};
    localparam int FO   [N] = '{8, 4, 8, 10};
    localparam int SG   [N] = '{1, 1, 0, 1};

    typedef struct {
        logic [16:0] exp;
        int          cyc;
        int          st;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] a, b;
    logic        round_mode;

    logic [N-1:0] ov, ir, of;
    logic [15:0]  res [N];

    int   total = 0;
    int   bad   = 0;
    ent_t q [N][$];
    int   stalls [N];
    int   pops [N];
    int   cyc = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        pipelined_fractional_multiplier_if #(
            .A_WIDTH(16), .B_WIDTH(16), .OUTPUT_WIDTH(16)
        ) bus ();
        assign bus.in_valid   = in_valid;
        assign bus.a          = a;
        assign bus.b          = b;
        assign bus.round_mode = round_mode;
        assign bus.out_ready  = out_ready;
        assign ov[g]  = bus.out_valid;
        assign ir[g]  = bus.in_ready;
        assign of[g]  = bus.overflow;
        assign res[g] = bus.result;

        pipelined_fractional_multiplier #(
            .A_WIDTH(16), .B_WIDTH(16), .OUTPUT_WIDTH(16),
            .FRAC_BITS_A(4), .FRAC_BITS_B(4), .FRAC_BITS_OUT(FO[g]),
            .ARE_SIGNALS_SIGNED(SG[g]), .PIPE_STAGES(PIPE[g])
        ) u_dut (
            .clk  (clk),
            .reset(reset),
            .bus  (bus)
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: exact product, scale by 2^-S with optional +half, clamp to range.
    function automatic logic [16:0] ref_calc(input int k, input logic [15:0] x,
                                             input logic [15:0] y, input logic rm);
        longint p, mx, mn;
        int s;
        if (SG[k] != 0) p = longint'($signed(x)) * longint'($signed(y));
        else            p = longint'(x) * longint'(y);
        s = 8 - FO[k];
        if (s > 0) begin
            if (rm) p = p + (longint'(1) << (s - 1));
            p = p >>> s;
        end else begin
            p = p <<< (-s);
        end
        mx = (SG[k] != 0) ? 64'sd32767 : 64'sd65535;
        mn = (SG[k] != 0) ? -64'sd32768 : 64'sd0;
        if (p > mx) return {1'b1, mx[15:0]};
        if (p < mn) return {1'b1, mn[15:0]};
        return {1'b0, p[15:0]};
    endfunction

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N; k++) q[k].delete();
        end else if (!clk) begin
            for (int k = 0; k < N; k++) begin
                if (ov[k]) begin
                    if (q[k].size() == 0) begin
                        check($sformatf("unexpected_out_dut%0d", k), 32'(ov[k]), 32'd0);
                    end else begin
                        check($sformatf("value_dut%0d", k), {15'd0, of[k], res[k]},
                              {15'd0, q[k][0].exp});
                        if (out_ready) begin
                            check($sformatf("latency_dut%0d", k),
                                  32'(cyc - q[k][0].cyc - (stalls[k] - q[k][0].st)),
                                  32'(PIPE[k]));
                            void'(q[k].pop_front());
                            pops[k]++;
                        end
                    end
                end
                if (ov[k] && !out_ready) stalls[k]++;
                if (in_valid && ir[k])
                    q[k].push_back('{exp: ref_calc(k, a, b, round_mode), cyc: cyc, st: stalls[k]});
            end
            cyc++;
        end
    end

    task automatic directed(input int k, input logic [15:0] x, input logic [15:0] y,
                            input logic rm, input logic [16:0] exp, input string tag);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1; a = x; b = y; round_mode = rm; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ov[k] && n < 20);
        check({tag, "_lat"}, 32'(n), 32'(PIPE[k]));
        check(tag, {15'd0, of[k], res[k]}, {15'd0, exp});
        repeat (8) @(posedge clk);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int pat [5] = '{1, 0, 1, 1, 0};
        int idx, p0;

        for (int k = 0; k < N; k++) begin
            stalls[k] = 0;
            pops[k] = 0;
        end
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; round_mode = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check($sformatf("rst_out_valid_%0d", k), 32'(ov[k]), 32'd0);
            check($sformatf("rst_result_%0d", k), 32'(res[k]), 32'd0);
            check($sformatf("rst_overflow_%0d", k), 32'(of[k]), 32'd0);
            check($sformatf("rst_in_ready_%0d", k), 32'(ir[k]), 32'd1);
        end
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        directed(0, 16'h0018, 16'h0024, 1'b0, 17'h00360, "t1_basic");
        directed(1, 16'h0019, 16'h0011, 1'b0, 17'h0001A, "t2_trunc");
        directed(1, 16'h0019, 16'h0011, 1'b1, 17'h0001B, "t2_round");
        directed(1, 16'hFFE7, 16'h0011, 1'b0, 17'h0FFE5, "t2_neg_trunc");
        directed(1, 16'hFFE7, 16'h0011, 1'b1, 17'h0FFE5, "t2_neg_round");
        directed(0, 16'h7FFF, 16'h7FFF, 1'b0, 17'h17FFF, "t3_sat_max");
        directed(0, 16'h8000, 16'h7FFF, 1'b0, 17'h18000, "t3_sat_min");
        directed(2, 16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFF, "t3_uns_sat");
        directed(3, 16'h0018, 16'h0024, 1'b0, 17'h00D80, "t_left_shift");

        // Backpressure: 8 held samples, consumer stalls for 3 cycles.
        idx = 0;
        p0 = pops[0];
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            out_ready  = !(i >= 4 && i < 7);
            in_valid   = (idx < 8);
            a          = 16'(idx * 37 + 5);
            b          = 16'(idx * 11 + 3);
            round_mode = idx[0];
            @(negedge clk);
            if (i >= 4 && i < 7) check("t4_stall_in_ready", 32'(ir[0]), 32'd0);
            if (in_valid && ir[0]) idx++;
        end
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) @(posedge clk);
        check("t4_result_count", 32'(pops[0] - p0), 32'd8);

        // Bubble pattern through the 5-deep instance.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            in_valid  = (i < 5) ? (pat[i] != 0) : 1'b0;
            a         = 16'($urandom);
            b         = 16'($urandom);
            out_ready = 1'b1;
            @(negedge clk);
            check("t5_bubble", 32'(ov[3]), (i >= 5 && i < 10) ? 32'(pat[i-5]) : 32'd0);
        end

        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            a          = pick();
            b          = pick();
            round_mode = 1'($urandom);
        end
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        repeat (12) @(posedge clk);

        // Asynchronous reset with two samples in flight.
        @(posedge clk); #1 in_valid = 1'b1; a = 16'h0030; b = 16'h0011; out_ready = 1'b1;
        @(posedge clk); #1 a = 16'h0044;
        @(posedge clk); #1 in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("t6_rst_out_valid", 32'(ov[0]), 32'd0);
        check("t6_rst_result", 32'(res[0]), 32'd0);
        check("t6_rst_out_valid_deep", 32'(ov[3]), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        directed(0, 16'h0018, 16'h0024, 1'b1, 17'h00360, "t6_fresh");

        for (int k = 0; k < N; k++)
            check($sformatf("drain_dut%0d", k), 32'(q[k].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
